// File: rtl/mvm_requant_buf_if.sv
// Stream bundle between the matrix-vector multiplier, the requantizing buffer and the next layer.
// master: the side that drives the input stream and the output back-pressure (upstream/downstream).
// slave:  the requantizing buffer itself.
interface mvm_requant_buf_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_overflow;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic               out_last;

    modport master (
        output in_valid, in_data, in_overflow, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_overflow, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/mvm_requant_buf.sv
// Requantizing result buffer: optional ReLU, rounding arithmetic right shift and saturation of
// 16-bit dot products to int8, collection of one NROWS-entry vector, then streaming it out.
// Single buffer: collect and emit phases never overlap.
module mvm_requant_buf #(
    parameter int unsigned NROWS   = 3,
    parameter int unsigned SHIFT   = 4,
    parameter bit          RELU_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active-low
    mvm_requant_buf_if.slave bus,
    input  logic             clr_flags,
    output logic             sat_flag,
    output logic             ovf_flag
);

    localparam int unsigned IdxW  = $clog2(NROWS);
    localparam int unsigned RndSh = (SHIFT == 0) ? 0 : SHIFT - 1;
    // Half-LSB rounding constant; zero when there is no shift.
    localparam logic signed [16:0] Rnd = (SHIFT == 0) ? 17'sd0 : (17'sd1 <<< RndSh);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NROWS - 1);

    typedef enum logic [0:0] {
        StCollect,
        StEmit
    } state_e;

    state_e            r_state;
    logic [IdxW-1:0]   r_idx;
    logic [7:0]        r_buf [NROWS];
    logic              r_out_valid;
    logic              r_out_last;
    logic [7:0]        r_out_data;
    logic              r_sat;
    logic              r_ovf;

    logic signed [16:0] w_r;
    logic signed [16:0] w_t;
    logic [7:0]         w_q;
    logic               w_sat;
    logic               w_accept;
    logic               w_emit;
    logic               w_idx_last;
    logic [IdxW-1:0]    w_idx_next;

    // Requantize the incoming dot product: ReLU, round-half-up shift, clamp to int8.
    always_comb begin
        w_r = {bus.in_data[15], bus.in_data};
        if (RELU_EN && bus.in_data[15]) begin
            w_r = '0;
        end
        // 17 bits hold 32767 + 2^13 without wrapping, so the shift sees the true sum.
        w_t   = (w_r + Rnd) >>> SHIFT;
        w_q   = w_t[7:0];
        w_sat = 1'b0;
        if (w_t > 17'sd127) begin
            w_q   = 8'h7f;
            w_sat = 1'b1;
        end else if (w_t < -17'sd128) begin
            w_q   = 8'h80;
            w_sat = 1'b1;
        end
    end

    // Handshake decode and index arithmetic.
    always_comb begin
        w_accept   = (r_state == StCollect) && bus.in_valid;
        w_emit     = r_out_valid && bus.out_ready;
        w_idx_last = (r_idx == IdxLast);
        w_idx_next = r_idx + IdxW'(1);
    end

    // Collect/emit sequencer with registered stream outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StCollect;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                StCollect: begin
                    if (w_accept) begin
                        if (w_idx_last) begin
                            // Entry 0 was written on an earlier accept since NROWS >= 2.
                            r_idx       <= '0;
                            r_state     <= StEmit;
                            r_out_valid <= 1'b1;
                            r_out_last  <= 1'b0;
                            r_out_data  <= r_buf[0];
                        end else begin
                            r_idx <= w_idx_next;
                        end
                    end
                end
                StEmit: begin
                    if (w_emit) begin
                        if (w_idx_last) begin
                            r_idx       <= '0;
                            r_state     <= StCollect;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_idx      <= w_idx_next;
                            r_out_data <= r_buf[w_idx_next];
                            r_out_last <= (w_idx_next == IdxLast);
                        end
                    end
                end
                default: begin
                    r_state <= StCollect;
                end
            endcase
        end
    end

    // Result storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_idx] <= w_q;
        end
    end

    // Sticky status flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_accept && w_sat) begin
                r_sat <= 1'b1;
            end else if (clr_flags) begin
                r_sat <= 1'b0;
            end
            if (w_accept && bus.in_overflow) begin
                r_ovf <= 1'b1;
            end else if (clr_flags) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == StCollect);
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = r_out_data;
    assign sat_flag      = r_sat;
    assign ovf_flag      = r_ovf;

endmodule

// File: tb/tb_mvm_requant_buf.sv
// Bench for mvm_requant_buf: two instances (ReLU on / ReLU off, SHIFT=4) share one stimulus
// stream; expected words are queued at issue time and popped by a monitor on each handshake.
module tb_mvm_requant_buf;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_flags;
    logic sat1, ovf1, sat0, ovf0;

    mvm_requant_buf_if if1 ();
    mvm_requant_buf_if if0 ();

    // Second instance sees exactly the same inputs as the first.
    assign if0.in_valid    = if1.in_valid;
    assign if0.in_data     = if1.in_data;
    assign if0.in_overflow = if1.in_overflow;
    assign if0.out_ready   = if1.out_ready;

    mvm_requant_buf #(.NROWS(3), .SHIFT(4), .RELU_EN(1'b1)) u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (if1.slave),
        .clr_flags (clr_flags),
        .sat_flag  (sat1),
        .ovf_flag  (ovf1)
    );

    mvm_requant_buf #(.NROWS(3), .SHIFT(4), .RELU_EN(1'b0)) u_dut_nr (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (if0.slave),
        .clr_flags (clr_flags),
        .sat_flag  (sat0),
        .ovf_flag  (ovf0)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   emit_cnt = 0;
    int   stall_left = 0;
    int   stall_len = 5;
    bit   arm_stall = 1'b0;
    exp_t q1[$];
    exp_t q0[$];

    // Directed vectors, SHIFT=4 so the rounding constant is 8.
    // e1 = ReLU on, e0 = ReLU off; 8'hFD=-3, 8'hFF=-1, 8'h80=-128.
    logic signed [15:0] vx  [5][3];
    logic [7:0]         ve1 [5][3];
    logic [7:0]         ve0 [5][3];

    initial begin
        // (100+8)>>>4=6, (-50+8)>>>4=-3, (40+8)>>>4=3
        vx[0] = '{16'sd100, -16'sd50, 16'sd40};
        ve1[0] = '{8'd6, 8'd0, 8'd3};       ve0[0] = '{8'd6, 8'hFD, 8'd3};
        // 5008>>>4=313 clamps; -32760>>>4=-2048 clamps; 32775>>>4=2048 clamps
        vx[1] = '{16'sd5000, -16'sd32768, 16'sd32767};
        ve1[1] = '{8'd127, 8'd0, 8'd127};   ve0[1] = '{8'd127, 8'h80, 8'd127};
        // -16>>>4=-1, 16>>>4=1 (half rounds up), 15>>>4=0
        vx[2] = '{-16'sd24, 16'sd8, 16'sd7};
        ve1[2] = '{8'd0, 8'd1, 8'd0};       ve0[2] = '{8'hFF, 8'd1, 8'd0};
        // -1>>>4=-1, 2047>>>4=127 and -2048>>>4=-128 are exact edges, no clamp
        vx[3] = '{-16'sd9, 16'sd2039, -16'sd2056};
        ve1[3] = '{8'd0, 8'd127, 8'd0};     ve0[3] = '{8'hFF, 8'd127, 8'h80};
        // 2048>>>4=128 and -2049>>>4=-129 are one past the edges and clamp; -8 -> 0
        vx[4] = '{16'sd2040, -16'sd2057, -16'sd8};
        ve1[4] = '{8'd127, 8'd0, 8'd0};     ve0[4] = '{8'd127, 8'h80, 8'd0};
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Present one word until accepted; expected outputs are queued immediately.
    task automatic push_word(input logic signed [15:0] x, input logic ovf, input logic [7:0] e1,
                             input logic [7:0] e0, input logic last);
        int n;
        bit done;
        if1.in_valid    = 1'b1;
        if1.in_data     = x;
        if1.in_overflow = ovf;
        q1.push_back('{data: e1, last: last});
        q0.push_back('{data: e0, last: last});
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (if1.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept timeout: got no accept expected accept of %0d", x);
        end
        if1.in_overflow = 1'b0;
    endtask

    task automatic send_vec(input int v, input bit hold_valid);
        for (int i = 0; i < 3; i++) begin
            push_word(vx[v][i], 1'b0, ve1[v][i], ve0[v][i], (i == 2));
        end
        check("out_valid one cycle after last accept", if1.out_valid, 1);
        if (!hold_valid) if1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain relu1 queue", q1.size(), 0);
        check("drain relu0 queue", q0.size(), 0);
    endtask

    // Downstream back-pressure: optionally stalls once when entry 1 is on the output.
    initial begin
        if1.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                if1.out_ready = 1'b0;
                stall_left--;
            end else if (arm_stall && if1.out_valid && (emit_cnt % 3 == 1)) begin
                if1.out_ready = 1'b0;
                stall_left = stall_len - 1;
                arm_stall = 1'b0;
            end else begin
                if1.out_ready = 1'b1;
            end
        end
    end

    // Monitor: compares each presented handshake against the scoreboards.
    initial begin
        exp_t e;
        bit   prev_stall1;
        bit   prev_stall0;
        logic [7:0] prev_d1;
        logic [7:0] prev_d0;
        prev_stall1 = 1'b0;
        prev_stall0 = 1'b0;
        prev_d1 = '0;
        prev_d0 = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("out_valid agrees across instances", if0.out_valid, if1.out_valid);
                if (if1.out_valid) begin
                    check("in_ready low while emitting", if1.in_ready, 0);
                    if (prev_stall1) check("relu1 data held", $signed(if1.out_data),
                                           $signed(prev_d1));
                    if (if1.out_ready) begin
                        if (q1.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL relu1 unexpected output: got %0d expected none",
                                     $signed(if1.out_data));
                        end else begin
                            e = q1.pop_front();
                            check("relu1 data", $signed(if1.out_data), $signed(e.data));
                            check("relu1 last", if1.out_last, e.last);
                        end
                        emit_cnt++;
                    end
                end
                if (if0.out_valid) begin
                    if (prev_stall0) check("relu0 data held", $signed(if0.out_data),
                                           $signed(prev_d0));
                    if (if0.out_ready) begin
                        if (q0.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL relu0 unexpected output: got %0d expected none",
                                     $signed(if0.out_data));
                        end else begin
                            e = q0.pop_front();
                            check("relu0 data", $signed(if0.out_data), $signed(e.data));
                            check("relu0 last", if0.out_last, e.last);
                        end
                    end
                end
            end
            prev_stall1 = rst_n && if1.out_valid && !if1.out_ready;
            prev_stall0 = rst_n && if0.out_valid && !if0.out_ready;
            prev_d1 = if1.out_data;
            prev_d0 = if0.out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 500000");
        $fatal(1, "watchdog");
    end

    // Main directed sequence.
    initial begin
        int n;
        if1.in_valid    = 1'b0;
        if1.in_data     = '0;
        if1.in_overflow = 1'b0;
        clr_flags       = 1'b0;
        rst_n           = 1'b0;

        // Reset state
        #12;
        check("reset out_valid", if1.out_valid, 0);
        check("reset out_last", if1.out_last, 0);
        check("reset out_data", if1.out_data, 0);
        check("reset sat_flag", sat1, 0);
        check("reset ovf_flag", ovf1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", if1.in_ready, 1);

        // T1: plain vector, no saturation
        send_vec(0, 1'b0);
        drain();
        check("T1 relu1 sat_flag", sat1, 0);
        check("T1 relu0 sat_flag", sat0, 0);

        // T2: full-scale inputs saturate
        send_vec(1, 1'b0);
        drain();
        check("T2 relu1 sat_flag", sat1, 1);
        check("T2 relu0 sat_flag", sat0, 1);
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        check("sat_flag cleared", sat1, 0);

        // T3+T4: back-to-back vectors with in_valid held, 5-cycle stall on entry 1
        stall_len = 5;
        arm_stall = 1'b1;
        send_vec(2, 1'b1);
        send_vec(3, 1'b1);
        check("edge values do not saturate relu1", sat1, 0);
        check("edge values do not saturate relu0", sat0, 0);
        send_vec(4, 1'b0);
        check("one past edge saturates relu1", sat1, 1);
        check("one past edge saturates relu0", sat0, 1);
        drain();
        check("stall was taken", arm_stall, 0);

        // T5: overflow flag set, sticky, cleared, and set winning over clear
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        check("ovf_flag clear before T5", ovf1, 0);
        push_word(16'sd100, 1'b1, 8'd6, 8'd6, 1'b0);
        check("ovf_flag set after accept", ovf1, 1);
        check("ovf_flag set relu0", ovf0, 1);
        push_word(-16'sd50, 1'b0, 8'd0, 8'hFD, 1'b0);
        check("ovf_flag sticky", ovf1, 1);
        push_word(16'sd40, 1'b0, 8'd3, 8'd3, 1'b1);
        if1.in_valid = 1'b0;
        drain();
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        check("ovf_flag cleared", ovf1, 0);
        push_word(16'sd100, 1'b1, 8'd6, 8'd6, 1'b0);
        clr_flags = 1'b0;
        check("ovf_flag set wins over clear", ovf1, 1);
        push_word(-16'sd50, 1'b0, 8'd0, 8'hFD, 1'b0);
        push_word(16'sd40, 1'b0, 8'd3, 8'd3, 1'b1);
        if1.in_valid = 1'b0;
        drain();

        // T6: asynchronous reset while emitting entry 1
        stall_len = 1000;
        arm_stall = 1'b1;
        send_vec(0, 1'b0);
        n = 0;
        while (stall_left == 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("T6 stall reached entry 1", (stall_left > 0), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("T6 out_valid drops in reset", if1.out_valid, 0);
        check("T6 out_valid drops in reset relu0", if0.out_valid, 0);
        check("T6 out_last drops in reset", if1.out_last, 0);
        check("T6 ovf_flag cleared by reset", ovf1, 0);
        q1.delete();
        q0.delete();
        stall_left = 0;
        arm_stall  = 1'b0;
        stall_len  = 5;
        emit_cnt   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("T6 in_ready after release", if1.in_ready, 1);
        check("T6 no output after release", if1.out_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        check("T6 pending vector discarded", if1.out_valid, 0);
        send_vec(1, 1'b0);
        drain();
        check("T6 sat_flag after fresh vector", sat1, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
